// File: rtl/tlb_cache_pkg.sv
// Shared widths, access-size encodings and line extract/merge helpers for the
// translating L1 cache.
package tlb_cache_pkg;
  localparam int WORD_SIZE       = 32;
  localparam int CACHE_LINE_SIZE = 128;
  localparam int PAGE_WIDTH      = 20;
  localparam int OFFSET_W        = WORD_SIZE - PAGE_WIDTH;
  localparam int TLB_ENTRIES     = 4;
  localparam int TLB_IDX_W       = 2;
  localparam int CACHE_LINES     = 4;
  localparam int INDEX_W         = 2;
  localparam int LINE_OFF_W      = 4;
  localparam int TAG_LSB         = LINE_OFF_W + INDEX_W;
  localparam int TAG_W           = WORD_SIZE - TAG_LSB;
  localparam logic [PAGE_WIDTH-1:0] VPAGE_LIMIT = 20'h80000;

  localparam logic [1:0] SIZE_BYTE      = 2'd0;
  localparam logic [1:0] SIZE_HALF      = 2'd1;
  localparam logic [1:0] SIZE_WORD      = 2'd2;
  localparam logic [1:0] FULL_WORD_SIZE = SIZE_WORD;

  function automatic logic [WORD_SIZE-1:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_mask = 32'h0000_00ff;
      SIZE_HALF: size_mask = 32'h0000_ffff;
      default:   size_mask = 32'hffff_ffff;
    endcase
  endfunction

  // Bytes past the end of the line shift in as zero, so misaligned reads
  // return only the part that falls inside the line.
  function automatic logic [WORD_SIZE-1:0] line_extract(
    input logic [CACHE_LINE_SIZE-1:0] line,
    input logic [LINE_OFF_W-1:0]      off,
    input logic [1:0]                 size
  );
    logic [CACHE_LINE_SIZE-1:0] sh;
    sh = line >> {off, 3'b000};
    line_extract = sh[WORD_SIZE-1:0] & size_mask(size);
  endfunction

  function automatic logic [CACHE_LINE_SIZE-1:0] line_merge(
    input logic [CACHE_LINE_SIZE-1:0] line,
    input logic [LINE_OFF_W-1:0]      off,
    input logic [WORD_SIZE-1:0]       value,
    input logic [1:0]                 size
  );
    logic [CACHE_LINE_SIZE-1:0] m;
    logic [CACHE_LINE_SIZE-1:0] v;
    m = {96'b0, size_mask(size)} << {off, 3'b000};
    v = {96'b0, value & size_mask(size)} << {off, 3'b000};
    line_merge = (line & ~m) | v;
  endfunction
endpackage

// File: rtl/tlb_cache_tlb.sv
// Fully-associative TLB: combinational lookup, identity-walk fill at the
// round-robin slot on a legal miss, exception for pages past the limit.
module tlb_cache_tlb
  import tlb_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [PAGE_WIDTH-1:0] vpage_i,
  output logic                  hit_o,
  output logic [PAGE_WIDTH-1:0] ppage_o,
  output logic                  exception_o
);
  logic [TLB_ENTRIES-1:0] ent_valid_q;
  logic [PAGE_WIDTH-1:0]  ent_vpage_q [TLB_ENTRIES];
  logic [PAGE_WIDTH-1:0]  ent_ppage_q [TLB_ENTRIES];
  logic [TLB_IDX_W-1:0]   rr_q, rr_d;
  logic                   fill;

  always_comb begin
    hit_o   = 1'b0;
    ppage_o = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (ent_valid_q[i] && (ent_vpage_q[i] == vpage_i)) begin
        hit_o   = 1'b1;
        ppage_o = ent_ppage_q[i];
      end
    end
  end

  assign exception_o = valid_i && (vpage_i >= VPAGE_LIMIT);
  assign fill        = valid_i && !hit_o && !exception_o;
  assign rr_d        = fill ? rr_q + 1'b1 : rr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid_q <= '0;
      rr_q        <= '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        ent_vpage_q[i] <= '0;
        ent_ppage_q[i] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      if (fill) begin
        ent_valid_q[rr_q] <= 1'b1;
        ent_vpage_q[rr_q] <= vpage_i;
        ent_ppage_q[rr_q] <= vpage_i;
      end
    end
  end
endmodule

// File: rtl/tlb_cache.sv
// Translating L1 cache: TLB front end plus a direct-mapped write-back line
// array with a single outstanding line fetch and a store-buffer drain port.
module tlb_cache
  import tlb_cache_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid,
  input  logic [WORD_SIZE-1:0]       vaddr,
  input  logic [1:0]                 load_size,
  input  logic                       store,
  output logic                       tlb_hit,
  output logic                       exception,
  output logic [WORD_SIZE-1:0]       paddr,
  output logic                       hit,
  output logic                       store_stall,
  output logic [WORD_SIZE-1:0]       read_data,
  output logic                       mem_req,
  output logic [WORD_SIZE-1:0]       mem_req_addr,
  input  logic                       mem_res,
  input  logic [WORD_SIZE-1:0]       mem_res_addr,
  input  logic [CACHE_LINE_SIZE-1:0] mem_res_data,
  output logic                       mem_write,
  output logic [WORD_SIZE-1:0]       mem_write_addr,
  output logic [CACHE_LINE_SIZE-1:0] mem_write_data,
  input  logic                       wenable,
  input  logic [WORD_SIZE-1:0]       sb_addr,
  input  logic [WORD_SIZE-1:0]       sb_value,
  input  logic [1:0]                 sb_size,
  output logic                       store_success
);
  logic [PAGE_WIDTH-1:0]      ppage;
  logic [CACHE_LINE_SIZE-1:0] data_q [CACHE_LINES];
  logic [TAG_W-1:0]           tag_q  [CACHE_LINES];
  logic [CACHE_LINES-1:0]     valid_q, dirty_q;
  logic                       pending_q, pending_d;
  logic [WORD_SIZE-LINE_OFF_W-1:0] pend_line_q, pend_line_d;
  logic [INDEX_W-1:0]         idx, fidx, sidx;
  logic                       lookup, fill, fill_same, present;
  logic [CACHE_LINE_SIZE-1:0] drain_base, drain_line;
  logic                       unused_res_lsbs;

  tlb_cache_tlb u_tlb (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid),
    .vpage_i     (vaddr[WORD_SIZE-1:OFFSET_W]),
    .hit_o       (tlb_hit),
    .ppage_o     (ppage),
    .exception_o (exception)
  );

  assign paddr  = tlb_hit ? {ppage, vaddr[OFFSET_W-1:0]} : '0;
  assign idx    = paddr[TAG_LSB-1:LINE_OFF_W];
  assign lookup = valid && tlb_hit;

  assign hit          = lookup && valid_q[idx] && (tag_q[idx] == paddr[WORD_SIZE-1:TAG_LSB]);
  assign read_data    = hit ? line_extract(data_q[idx], paddr[LINE_OFF_W-1:0], load_size) : '0;
  assign store_stall  = store && lookup && !hit;
  assign mem_req      = lookup && !hit && !pending_q;
  assign mem_req_addr = {paddr[WORD_SIZE-1:LINE_OFF_W], 4'b0};

  // Only the line address of a response matters; the offset bits are ignored.
  assign unused_res_lsbs = ^mem_res_addr[LINE_OFF_W-1:0];
  assign fill = pending_q && mem_res && (mem_res_addr[WORD_SIZE-1:LINE_OFF_W] == pend_line_q);
  assign fidx = mem_res_addr[TAG_LSB-1:LINE_OFF_W];

  assign mem_write      = fill && valid_q[fidx] && dirty_q[fidx];
  assign mem_write_addr = mem_write ? {tag_q[fidx], fidx, 4'b0} : '0;
  assign mem_write_data = mem_write ? data_q[fidx] : '0;

  // A drain landing on the line being filled this edge sees the incoming
  // line, so the fill and the merge commit together.
  assign sidx       = sb_addr[TAG_LSB-1:LINE_OFF_W];
  assign fill_same  = fill && (fidx == sidx);
  assign present    = fill_same ? (mem_res_addr[WORD_SIZE-1:TAG_LSB] == sb_addr[WORD_SIZE-1:TAG_LSB])
                                : (valid_q[sidx] && (tag_q[sidx] == sb_addr[WORD_SIZE-1:TAG_LSB]));
  assign store_success = wenable && present;
  assign drain_base = fill_same ? mem_res_data : data_q[sidx];
  assign drain_line = line_merge(drain_base, sb_addr[LINE_OFF_W-1:0], sb_value, sb_size);

  always_comb begin
    pending_d   = pending_q;
    pend_line_d = pend_line_q;
    if (fill) pending_d = 1'b0;
    if (mem_req) begin
      pending_d   = 1'b1;
      pend_line_d = paddr[WORD_SIZE-1:LINE_OFF_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= '0;
      dirty_q     <= '0;
      pending_q   <= 1'b0;
      pend_line_q <= '0;
      for (int i = 0; i < CACHE_LINES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      pending_q   <= pending_d;
      pend_line_q <= pend_line_d;
      if (fill) begin
        data_q[fidx]  <= mem_res_data;
        tag_q[fidx]   <= mem_res_addr[WORD_SIZE-1:TAG_LSB];
        valid_q[fidx] <= 1'b1;
        dirty_q[fidx] <= 1'b0;
      end
      if (store_success) begin
        data_q[sidx]  <= drain_line;
        dirty_q[sidx] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tlb_cache.sv
// Bench for tlb_cache: directed walk through the basic scenarios, then
// randomized traffic against a byte-level reference model with a memory responder.
module tb_tlb_cache;
  import tlb_cache_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid, store, wenable, mem_res;
  logic [31:0]  vaddr, sb_addr, sb_value, mem_res_addr;
  logic [1:0]   load_size, sb_size;
  logic [127:0] mem_res_data;
  logic         tlb_hit, exception, hit, store_stall, mem_req, mem_write, store_success;
  logic [31:0]  paddr, read_data, mem_req_addr, mem_write_addr;
  logic [127:0] mem_write_data;

  tlb_cache dut (
    .clk(clk), .rst(rst), .valid(valid), .vaddr(vaddr), .load_size(load_size), .store(store),
    .tlb_hit(tlb_hit), .exception(exception), .paddr(paddr), .hit(hit),
    .store_stall(store_stall), .read_data(read_data), .mem_req(mem_req),
    .mem_req_addr(mem_req_addr), .mem_res(mem_res), .mem_res_addr(mem_res_addr),
    .mem_res_data(mem_res_data), .mem_write(mem_write), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .wenable(wenable), .sb_addr(sb_addr),
    .sb_value(sb_value), .sb_size(sb_size), .store_success(store_success)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: TLB as a FIFO of pages, cache as byte arrays keyed by line address.
  bit [19:0]  tlb_q[$];
  bit         c_val [4];
  bit         c_dirty [4];
  bit [27:0]  c_line [4];
  bit [7:0]   c_byte [4][16];
  bit         m_pend;
  bit [27:0]  m_pend_line;
  logic [127:0] mem [bit [27:0]];

  bit         resp_active = 0;
  bit [27:0]  resp_line;
  int         resp_cnt, resp_min, resp_max;

  bit e_tlb, e_exc, e_hit, e_req, e_stall, e_fill, e_wb, e_ss;
  logic [31:0]  e_paddr, e_rd, e_wb_addr;
  logic [127:0] e_wb_data;
  int fidx, sidx;

  function automatic int nbytes(input logic [1:0] s);
    return (s == SIZE_BYTE) ? 1 : (s == SIZE_HALF) ? 2 : 4;
  endfunction

  function automatic logic [127:0] model_line(input int i);
    logic [127:0] r = '0;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = c_byte[i][k];
    return r;
  endfunction

  function automatic logic [127:0] mem_line(input bit [27:0] l);
    if (!mem.exists(l)) mem[l] = {$urandom, $urandom, $urandom, $urandom};
    return mem[l];
  endfunction

  task automatic model_clear();
    tlb_q.delete();
    for (int i = 0; i < 4; i++) begin c_val[i] = 0; c_dirty[i] = 0; end
    m_pend = 0;
  endtask

  task automatic model_eval();
    bit [19:0] vp;
    bit present;
    int idx, off;
    vp = vaddr[31:12];
    e_tlb = 0;
    foreach (tlb_q[i]) if (tlb_q[i] == vp) e_tlb = 1;
    e_exc   = valid && (vp >= 20'h80000);
    e_paddr = e_tlb ? vaddr : 32'h0;
    idx = int'(vaddr[5:4]);
    off = int'(vaddr[3:0]);
    e_hit = valid && e_tlb && c_val[idx] && (c_line[idx] == vaddr[31:4]);
    e_rd = '0;
    if (e_hit)
      for (int k = 0; k < nbytes(load_size); k++)
        if (off + k < 16) e_rd[8*k +: 8] = c_byte[idx][off+k];
    e_req   = valid && e_tlb && !e_hit && !m_pend;
    e_stall = store && valid && e_tlb && !e_hit;
    e_fill  = m_pend && mem_res && (mem_res_addr[31:4] == m_pend_line);
    fidx = int'(m_pend_line[1:0]);
    e_wb = e_fill && c_val[fidx] && c_dirty[fidx];
    e_wb_addr = {c_line[fidx], 4'b0};
    e_wb_data = model_line(fidx);
    sidx = int'(sb_addr[5:4]);
    if (e_fill && fidx == sidx) present = (m_pend_line == sb_addr[31:4]);
    else present = c_val[sidx] && (c_line[sidx] == sb_addr[31:4]);
    e_ss = wenable && present;
  endtask

  task automatic model_commit();
    int off;
    if (valid && !e_tlb && vaddr[31:12] < 20'h80000) begin
      tlb_q.push_back(vaddr[31:12]);
      if (tlb_q.size() > 4) void'(tlb_q.pop_front());
    end
    if (e_wb) mem[c_line[fidx]] = e_wb_data;
    if (e_fill) begin
      c_val[fidx] = 1; c_dirty[fidx] = 0; c_line[fidx] = m_pend_line;
      for (int k = 0; k < 16; k++) c_byte[fidx][k] = mem_res_data[8*k +: 8];
      m_pend = 0;
    end
    if (e_ss) begin
      off = int'(sb_addr[3:0]);
      for (int k = 0; k < nbytes(sb_size); k++)
        if (off + k < 16) c_byte[sidx][off+k] = sb_value[8*k +: 8];
      c_dirty[sidx] = 1;
    end
    if (e_req) begin
      m_pend = 1; m_pend_line = vaddr[31:4];
      resp_active = 1; resp_line = vaddr[31:4];
      resp_cnt = $urandom_range(resp_min, resp_max);
    end
  endtask

  task automatic drive_mem();
    mem_res = 0; mem_res_addr = '0; mem_res_data = '0;
    if (resp_active) begin
      if (resp_cnt == 0) begin
        mem_res = 1; mem_res_addr = {resp_line, 4'b0}; mem_res_data = mem_line(resp_line);
        resp_active = 0;
      end else begin
        resp_cnt--;
        if ($urandom_range(0, 7) == 0) begin
          mem_res = 1; mem_res_addr = {resp_line + 28'd1, 4'b0};
          mem_res_data = {4{$urandom}};
        end
      end
    end
  endtask

  task automatic half_a();
    drive_mem();
    @(negedge clk);
    model_eval();
    check("tlb_hit", tlb_hit, e_tlb);
    check("exception", exception, e_exc);
    check("paddr", paddr, e_paddr);
    check("hit", hit, e_hit);
    check("read_data", read_data, e_rd);
    check("store_stall", store_stall, e_stall);
    if (e_req) exp_q.push_back({vaddr[31:4], 4'b0});
    check("mem_req", mem_req, e_req);
    if (mem_req && exp_q.size() > 0) check("mem_req_addr", mem_req_addr, exp_q.pop_front());
    check("mem_write", mem_write, e_wb);
    if (e_wb) begin
      check("wb_addr", mem_write_addr, e_wb_addr);
      check("wb_data", mem_write_data, e_wb_data);
    end
    check("store_success", store_success, e_ss);
  endtask

  task automatic half_b();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_acc(input logic [31:0] a, input logic [1:0] s, input logic st);
    valid = 1; vaddr = a; load_size = s; store = st; wenable = 0;
  endtask

  task automatic do_reset();
    rst = 0; valid = 0; vaddr = '0; load_size = '0; store = 0;
    wenable = 0; sb_addr = '0; sb_value = '0; sb_size = '0;
    model_clear();
    half_a();
    check("reset_outs_a", {tlb_hit, exception, paddr, hit, store_stall, read_data, mem_req, mem_req_addr}, '0);
    check("reset_outs_b", {mem_write, mem_write_addr, store_success}, '0);
    half_b();
    rst = 1;
  endtask

  initial begin
    rst = 0;
    resp_min = 0; resp_max = 0;
    mem[28'h100] = 128'hCCCCBBBB_AAAA9999_88776655_44332211;
    #1;
    do_reset();

    set_acc(32'h1000, SIZE_WORD, 0);
    half_a(); check("t1_cold_tlb", tlb_hit, 0); half_b();
    half_a(); check("t1_req", mem_req, 1); check("t1_req_addr", mem_req_addr, 32'h1000); half_b();
    half_a(); half_b();
    half_a(); check("t1_hit", hit, 1); check("t1_data", read_data, 32'h44332211); half_b();
    set_acc(32'h1002, SIZE_BYTE, 0);
    half_a(); check("t2_byte", read_data, 32'h33); half_b();
    set_acc(32'h1000, SIZE_HALF, 0);
    half_a(); check("t2_half", read_data, 32'h2211); half_b();

    valid = 0; wenable = 1; sb_addr = 32'h1004; sb_value = 32'hDEADBEEF; sb_size = SIZE_WORD;
    half_a(); check("t3_store_success", store_success, 1); half_b();
    set_acc(32'h1004, SIZE_WORD, 0);
    half_a(); check("t3_reload", read_data, 32'hDEADBEEF); half_b();

    set_acc(32'h1040, SIZE_WORD, 0);
    half_a(); check("t4_req", {mem_req, mem_req_addr}, {1'b1, 32'h1040}); half_b();
    half_a();
    check("t4_wb", mem_write, 1);
    check("t4_wb_addr", mem_write_addr, 32'h1000);
    check("t4_wb_word", mem_write_data[63:32], 32'hDEADBEEF);
    half_b();

    set_acc(32'h8000_0000, SIZE_WORD, 0);
    half_a(); check("t5_exc", exception, 1); check("t5_hit_req", {hit, mem_req}, 2'b00); half_b();

    resp_min = 2; resp_max = 2;
    set_acc(32'h2000, SIZE_WORD, 1);
    half_a(); check("t6_tlb_miss", {tlb_hit, store_stall}, 2'b00); half_b();
    half_a(); check("t6_stall", {store_stall, mem_req}, 2'b11); half_b();
    do_reset();
    for (int i = 0; i < 3; i++) begin half_a(); half_b(); end
    set_acc(32'h2000, SIZE_WORD, 0);
    half_a(); half_b();
    half_a(); check("t6_rereq", mem_req, 1); half_b();

    resp_min = 0; resp_max = 3;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        continue;
      end
      valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0)
        vaddr = {20'h80000 + 20'($urandom_range(0, 15)), 12'($urandom)};
      else
        vaddr = {20'($urandom_range(0, 5)), 4'h0, 8'($urandom)};
      load_size = 2'($urandom_range(0, 2));
      store = ($urandom_range(0, 9) < 3);
      wenable = ($urandom_range(0, 9) < 3);
      if (m_pend && $urandom_range(0, 2) == 0) sb_addr = {m_pend_line, 4'($urandom)};
      else sb_addr = {20'($urandom_range(0, 5)), 4'h0, 8'($urandom)};
      sb_value = $urandom;
      sb_size = 2'($urandom_range(0, 2));
      half_a();
      half_b();
    end

    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
